// File: rtl/iecdrv_blk_server_pkg.sv
// Shared definitions for the track-buffer block server.
package iecdrv_blk_pkg;

    // Default log2 of bytes moved per request (8 KiB tracks).
    localparam int TRK_LOG2_DEF = 13;

    // Controller states.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ACCEPT    = 4'd1,
        ST_RD_REQ    = 4'd2,
        ST_RD_WAIT   = 4'd3,
        ST_RD_STORE  = 4'd4,
        ST_WR_FETCH  = 4'd5,
        ST_WR_SAMPLE = 4'd6,
        ST_WR_REQ    = 4'd7,
        ST_WR_WAIT   = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

endpackage

// File: rtl/iecdrv_blk_server_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
module iecdrv_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Double-register the asynchronous input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iecdrv_blk_server.sv
// Track-buffer block server: moves one track between the requester's
// track buffer and the mounted image, one byte at a time.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for sd_rd / sd_wr
// ACCEPT     | lba latched, range check evaluated
// RD_REQ     | mem_rd pulse for image byte idx
// RD_WAIT    | waiting for mem_ready, capture mem_din
// RD_STORE   | sd_buff_wr pulse, idx advances (zero-fill loop if out of range)
// WR_FETCH   | present idx to the track buffer
// WR_SAMPLE  | capture sd_buff_din into mem_dout
// WR_REQ     | mem_wr pulse
// WR_WAIT    | waiting for mem_ready, idx advances
// DONE       | last cycle of sd_ack
module iecdrv_blk_server
    import iecdrv_blk_pkg::*;
#(
    parameter int TRK_LOG2 = TRK_LOG2_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         sd_lba,
    input  logic                sd_rd,
    input  logic                sd_wr,
    output logic                sd_ack,
    output logic [TRK_LOG2-1:0] sd_buff_addr,
    output logic [7:0]          sd_buff_dout,
    input  logic [7:0]          sd_buff_din,
    output logic                sd_buff_wr,
    input  logic                img_mounted,
    input  logic [31:0]         img_size,
    output logic [31:0]         mem_addr,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [7:0]          mem_dout,
    input  logic [7:0]          mem_din,
    input  logic                mem_ready
);

    state_e              state;
    logic [31:0]         lba_q;
    logic [TRK_LOG2-1:0] idx;
    logic                is_rd;
    logic                in_range;
    logic                mounted_s;
    logic [32:0]         trk_end;
    logic                range_ok;
    logic                idx_last;

    iecdrv_sync #(.W(1)) u_sync_mnt (
        .clk   (clk),
        .reset (reset),
        .d     (img_mounted),
        .q     (mounted_s)
    );

    // End of the requested track; 33 bits so a track ending exactly at 4 GiB still compares.
    assign trk_end  = ({1'b0, lba_q} + 33'd1) << TRK_LOG2;
    assign range_ok = mounted_s && (trk_end <= {1'b0, img_size});
    assign idx_last = &idx;

    // Strobes and addresses decode straight from state so reset clears them without a clock.
    assign sd_ack       = (state != ST_IDLE);
    assign mem_rd       = (state == ST_RD_REQ);
    assign mem_wr       = (state == ST_WR_REQ);
    assign sd_buff_wr   = (state == ST_RD_STORE);
    assign sd_buff_addr = idx;
    assign mem_addr     = {lba_q[31-TRK_LOG2:0], idx};

    // Sequencer, byte counter and data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            lba_q        <= '0;
            idx          <= '0;
            is_rd        <= 1'b0;
            in_range     <= 1'b0;
            sd_buff_dout <= '0;
            mem_dout     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sd_rd || sd_wr) begin
                        lba_q <= sd_lba;
                        idx   <= '0;
                        is_rd <= sd_rd;
                        state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    in_range     <= range_ok;
                    sd_buff_dout <= '0;
                    if (is_rd)
                        state <= range_ok ? ST_RD_REQ : ST_RD_STORE;
                    else
                        state <= range_ok ? ST_WR_FETCH : ST_DONE;
                end
                ST_RD_REQ: state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (mem_ready) begin
                        sd_buff_dout <= mem_din;
                        state        <= ST_RD_STORE;
                    end
                end
                ST_RD_STORE: begin
                    idx <= idx + 1'b1;
                    if (idx_last)
                        state <= ST_DONE;
                    else if (in_range)
                        state <= ST_RD_REQ;
                end
                ST_WR_FETCH:  state <= ST_WR_SAMPLE;
                ST_WR_SAMPLE: begin
                    mem_dout <= sd_buff_din;
                    state    <= ST_WR_REQ;
                end
                ST_WR_REQ: state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (mem_ready) begin
                        idx   <= idx + 1'b1;
                        state <= idx_last ? ST_DONE : ST_WR_FETCH;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iecdrv_blk_server.sv
// Directed bench for iecdrv_blk_server. Track geometry is scaled down
// (TRK_LOG2=10, image 0x2000 bytes = 8 tracks) to keep the run short;
// lba 7 is the last in-range track and lba 8 is the first out of range.
module tb_iecdrv_blk_server;

    localparam int L = 10;
    localparam int T = 1 << L;
    localparam int RD_ACK = 3 * T + 2;
    localparam int WR_ACK = 4 * T + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   sd_lba = '0;
    logic          sd_rd = 1'b0;
    logic          sd_wr = 1'b0;
    logic          sd_ack;
    logic [L-1:0]  sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic [7:0]    sd_buff_din = '0;
    logic          sd_buff_wr;
    logic          img_mounted = 1'b1;
    logic [31:0]   img_size = 32'h2000;
    logic [31:0]   mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic [7:0]    mem_din = '0;
    logic          mem_ready = 1'b0;

    iecdrv_blk_server #(.TRK_LOG2(L)) dut (
        .clk          (clk),
        .reset        (reset),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected image content and track addressing.
    function automatic logic [7:0] img_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] trk_addr(input logic [31:0] lba, input int i);
        return (lba << L) | 32'(i);
    endfunction

    logic [7:0]  tbuf [T];
    logic [L-1:0] din_addr = '0;
    logic [31:0] exp_lba = '0;
    bit          exp_inrange = 1'b1;
    bit          rand_delay = 1'b0;
    int          fixed_delay = 0;

    int buf_wr_cnt, buf_addr_err, buf_data_err, wrap_cnt, wr_seq;
    int mrd_cnt, mrd_addr_err, rd_seq;
    int mwr_cnt, mwr_addr_err, mwr_data_err, wseq;
    int overlap_cnt, ack_rise, ack_high;
    bit ack_prev = 1'b0;
    bit pend = 1'b0;
    int wait_cnt = 0;
    logic [31:0] paddr = '0;

    task automatic clear_stats();
        buf_wr_cnt = 0; buf_addr_err = 0; buf_data_err = 0; wrap_cnt = 0; wr_seq = 0;
        mrd_cnt = 0; mrd_addr_err = 0; rd_seq = 0;
        mwr_cnt = 0; mwr_addr_err = 0; mwr_data_err = 0; wseq = 0;
        overlap_cnt = 0; ack_rise = 0; ack_high = 0;
    endtask

    // Track buffer, image memory responder and protocol monitor, all on the falling edge.
    always @(negedge clk) begin
        logic [7:0] ex;
        sd_buff_din = tbuf[din_addr];
        din_addr    = sd_buff_addr;

        mem_ready = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                mem_ready = 1'b1;
                mem_din   = img_byte(paddr);
                pend      = 1'b0;
            end else begin
                wait_cnt--;
            end
        end

        if (!reset) begin
            if (int'(sd_buff_wr) + int'(mem_rd) + int'(mem_wr) > 1) overlap_cnt++;
            if (sd_ack && !ack_prev) ack_rise++;
            if (sd_ack) ack_high++;

            if (sd_buff_wr) begin
                buf_wr_cnt++;
                if (sd_buff_addr != L'(wr_seq)) buf_addr_err++;
                ex = exp_inrange ? img_byte(trk_addr(exp_lba, int'(sd_buff_addr))) : 8'h00;
                if (sd_buff_dout !== ex) buf_data_err++;
                tbuf[sd_buff_addr] = sd_buff_dout;
                if (&sd_buff_addr) wrap_cnt++;
                wr_seq = (wr_seq + 1) % T;
            end

            if (mem_rd) begin
                mrd_cnt++;
                if (mem_addr !== trk_addr(exp_lba, rd_seq)) mrd_addr_err++;
                rd_seq   = (rd_seq + 1) % T;
                pend     = 1'b1;
                paddr    = mem_addr;
                wait_cnt = rand_delay ? int'($urandom_range(0, 7)) : fixed_delay;
            end

            if (mem_wr) begin
                mwr_cnt++;
                if (mem_addr !== trk_addr(exp_lba, wseq)) mwr_addr_err++;
                if (mem_dout !== (mem_addr[7:0] ^ 8'hA5)) mwr_data_err++;
                wseq     = (wseq + 1) % T;
                pend     = 1'b1;
                paddr    = mem_addr;
                wait_cnt = fixed_delay;
            end
        end
        ack_prev = sd_ack;
    end

    // Issue one request, drop it on sd_ack, scramble lba, wait for sd_ack to fall.
    task automatic run_req(input string tag, input bit rd, input bit wr,
                           input logic [31:0] lba, input int budget, input bit glitch_mnt);
        int n;
        @(negedge clk);
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        n = 0;
        while (!sd_ack && n < 10) begin @(negedge clk); n++; end
        sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = lba ^ 32'hDEAD_BEEF;
        if (!sd_ack) begin
            check({tag, "_accept_timeout"}, 1, 0);
            return;
        end
        if (glitch_mnt) img_mounted = 1'b0;
        n = 0;
        while (sd_ack && n < budget) begin @(negedge clk); n++; end
        if (sd_ack) check({tag, "_done_timeout"}, 1, 0);
        img_mounted = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [63:0] outs();
        return {2'b00, sd_ack, sd_buff_wr, mem_rd, mem_wr, sd_buff_addr,
                sd_buff_dout, mem_addr, mem_dout};
    endfunction

    initial begin
        int snap_wr, snap_rise, snap_rd, n;
        clear_stats();
        for (int i = 0; i < T; i++) tbuf[i] = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_no_ack", {63'd0, sd_ack}, 0);

        // In-range read, lba 3
        clear_stats(); exp_lba = 3; exp_inrange = 1'b1;
        run_req("rd3", 1'b1, 1'b0, 32'd3, 5 * T, 1'b0);
        check("rd3_buf_writes", buf_wr_cnt, T);
        check("rd3_mem_reads", mrd_cnt, T);
        check("rd3_mem_addr_err", mrd_addr_err, 0);
        check("rd3_buf_addr_err", buf_addr_err, 0);
        check("rd3_data_err", buf_data_err, 0);
        check("rd3_ack_cycles", ack_high, RD_ACK);
        check("rd3_no_mem_wr", mwr_cnt, 0);

        // In-range write, lba 1, mount glitch during the transfer must not matter
        for (int i = 0; i < T; i++) tbuf[i] = 8'(i) ^ 8'hA5;
        clear_stats(); exp_lba = 1;
        run_req("wr1", 1'b0, 1'b1, 32'd1, 6 * T, 1'b1);
        check("wr1_mem_writes", mwr_cnt, T);
        check("wr1_addr_err", mwr_addr_err, 0);
        check("wr1_data_err", mwr_data_err, 0);
        check("wr1_ack_cycles", ack_high, WR_ACK);
        check("wr1_no_buf_wr", buf_wr_cnt + mrd_cnt, 0);

        // Out-of-range read, lba 8: zero fill, one byte per cycle
        clear_stats(); exp_lba = 8; exp_inrange = 1'b0;
        run_req("rd8", 1'b1, 1'b0, 32'd8, 3 * T, 1'b0);
        check("rd8_buf_writes", buf_wr_cnt, T);
        check("rd8_zero_err", buf_data_err + buf_addr_err, 0);
        check("rd8_no_mem_rd", mrd_cnt, 0);
        check("rd8_ack_cycles", ack_high, T + 2);

        // Out-of-range write, lba 8: ack pulse only
        clear_stats();
        run_req("wr8", 1'b0, 1'b1, 32'd8, 100, 1'b0);
        check("wr8_no_access", mwr_cnt + mrd_cnt + buf_wr_cnt, 0);
        check("wr8_ack_cycles", ack_high, 2);

        // Unmounted image, lba 0 write is discarded
        img_mounted = 1'b0;
        repeat (4) @(negedge clk);
        clear_stats();
        run_req("unmnt", 1'b0, 1'b1, 32'd0, 100, 1'b0);
        check("unmnt_no_mem_wr", mwr_cnt, 0);
        check("unmnt_ack_cycles", ack_high, 2);
        img_mounted = 1'b1;
        repeat (4) @(negedge clk);

        // Read and write together on the last in-range track: read wins, one accept
        clear_stats(); exp_lba = 7; exp_inrange = 1'b1;
        run_req("both7", 1'b1, 1'b1, 32'd7, 5 * T, 1'b0);
        check("both7_mem_reads", mrd_cnt, T);
        check("both7_no_mem_wr", mwr_cnt, 0);
        check("both7_data_err", buf_data_err + buf_addr_err + mrd_addr_err, 0);
        check("both7_single_accept", ack_rise, 1);

        // Random memory latency, lba 0
        clear_stats(); exp_lba = 0; rand_delay = 1'b1;
        run_req("rnd0", 1'b1, 1'b0, 32'd0, 12 * T, 1'b0);
        rand_delay = 1'b0;
        check("rnd0_buf_writes", buf_wr_cnt, T);
        check("rnd0_data_err", buf_data_err + buf_addr_err + mrd_addr_err, 0);
        check("rnd0_overlap", overlap_cnt, 0);
        check("rnd0_wraps", wrap_cnt, 1);

        // Reset during a read with a memory response still outstanding
        clear_stats(); exp_lba = 0; fixed_delay = 3;
        @(negedge clk);
        sd_lba = 32'd0; sd_rd = 1'b1;
        n = 0;
        while (!sd_ack && n < 10) begin @(negedge clk); n++; end
        sd_rd = 1'b0;
        n = 0;
        while (buf_wr_cnt < 100 && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (!mem_rd && n < 20) begin @(negedge clk); n++; end
        check("rstmid_reached_byte100", {63'd0, mem_rd}, 1);
        #1 reset = 1'b1;
        #1 check("rstmid_outs", outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        snap_wr = buf_wr_cnt; snap_rise = ack_rise; snap_rd = mrd_cnt;
        repeat (10) @(negedge clk);
        check("rstmid_no_ack", ack_rise - snap_rise, 0);
        check("rstmid_no_activity", (buf_wr_cnt - snap_wr) + (mrd_cnt - snap_rd), 0);
        fixed_delay = 0;

        // Fresh request after reset starts at idx 0
        clear_stats(); exp_lba = 2;
        run_req("rd2", 1'b1, 1'b0, 32'd2, 5 * T, 1'b0);
        check("rd2_buf_writes", buf_wr_cnt, T);
        check("rd2_err", buf_data_err + buf_addr_err + mrd_addr_err, 0);
        check("rd2_ack_cycles", ack_high, RD_ACK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
